irq_factor_bank: RTL and testbench

Parametrised interrupt factor/mask register bank for the E0C6S46 I/O page (0xF00–0xFFF). Each of CHANNELS channels holds up to 4 factor flags, set by edge- or level-detected event sources and cleared on CPU read, plus a CPU-writable mask nibble. It replaces the hand-coded factor/mask decode in the RAM bus and drives the per-channel interrupt request lines toward the `interrupt` module.

---
 rtl/irq_factor_bank.sv | 147 ++++++++++++++
 tb/tb_irq_factor_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_factor_bank.sv
// irq_factor_bank
// Interrupt factor/mask register bank in the E0C6S46 I/O page (0xF00-0xFFF).
// Each channel has up to 4 factor flags, set by source events and cleared
// when the CPU reads them, and a CPU-writable mask nibble that gates the
// channel's interrupt request.
//
// Ports
//   clk               system clock
//   reset_n           synchronous active-low reset
//   memory_addr       CPU data address (12 bits)
//   memory_write_en   write strobe, one cycle per access
//   memory_write_data write nibble
//   source            event inputs, bit c*WIDTH+i feeds flag i of channel c
//   read_data         registered read nibble for a bank hit
//   read_hit          registered, high when read_data belongs to this bank
//   irq_req           registered per-channel request, |(factor & mask)
//   irq_any           registered OR of all channel requests
module irq_factor_bank #(
    parameter int unsigned CHANNELS    = 6,
    parameter int unsigned WIDTH       = 4,
    parameter logic [7:0]  FACTOR_BASE = 8'h00,
    parameter logic [7:0]  MASK_BASE   = 8'h10,
    parameter bit          EDGE_MODE   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [11:0]                 memory_addr,
    input  logic                        memory_write_en,
    input  logic [3:0]                  memory_write_data,
    input  logic [CHANNELS*WIDTH-1:0]   source,
    output logic [3:0]                  read_data,
    output logic                        read_hit,
    output logic [CHANNELS-1:0]         irq_req,
    output logic                        irq_any
);

    localparam int unsigned FLAGS  = CHANNELS * WIDTH;
    localparam int unsigned F_LO   = 32'(FACTOR_BASE);
    localparam int unsigned F_HI   = F_LO + CHANNELS;
    localparam int unsigned M_LO   = 32'(MASK_BASE);
    localparam int unsigned M_HI   = M_LO + CHANNELS;

    // Parameter sanity: legal sizes, ranges inside the page, no overlap.
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("irq_factor_bank: CHANNELS must be 1..16");
    end
    if (WIDTH < 1 || WIDTH > 4) begin : g_bad_width
        $error("irq_factor_bank: WIDTH must be 1..4");
    end
    if (F_HI > 256 || M_HI > 256) begin : g_bad_range
        $error("irq_factor_bank: register range exceeds I/O page");
    end
    if (F_LO < M_HI && M_LO < F_HI) begin : g_overlap
        $error("irq_factor_bank: factor and mask ranges overlap");
    end

    logic [FLAGS-1:0]                 src_q;
    logic [CHANNELS-1:0][WIDTH-1:0]   factor_q, factor_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   mask_q,   mask_d;
    logic [3:0]                       read_data_q, read_data_d;
    logic                             read_hit_q,  read_hit_d;
    logic [CHANNELS-1:0]              irq_req_q,   irq_req_d;
    logic                             irq_any_q,   irq_any_d;

    logic [CHANNELS-1:0][WIDTH-1:0]   set_flags;
    logic [CHANNELS-1:0][WIDTH-1:0]   clr_flags;
    logic [CHANNELS-1:0]              fac_sel;
    logic [CHANNELS-1:0]              msk_sel;
    logic                             page_hit;

    // Event detection: rising edge against last cycle's source, or raw level.
    always_comb begin
        set_flags = '0;
        if (EDGE_MODE) begin
            set_flags = source & ~src_q;
        end else begin
            set_flags = source;
        end
    end

    // Address decode into one-hot per-channel selects.
    always_comb begin
        fac_sel  = '0;
        msk_sel  = '0;
        page_hit = (memory_addr[11:8] == 4'hF);
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            fac_sel[c] = page_hit && (memory_addr[7:0] == 8'(F_LO + c));
            msk_sel[c] = page_hit && (memory_addr[7:0] == 8'(M_LO + c));
        end
    end

    // Next-state: register access, clear-on-read, flag update and requests.
    always_comb begin
        factor_d    = factor_q;
        mask_d      = mask_q;
        read_data_d = 4'h0;
        read_hit_d  = 1'b0;
        clr_flags   = '0;
        irq_req_d   = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (fac_sel[c] && !memory_write_en) begin
                read_data_d  = read_data_d | 4'(factor_q[c]);
                read_hit_d   = 1'b1;
                clr_flags[c] = '1;
            end
            if (msk_sel[c]) begin
                if (memory_write_en) begin
                    mask_d[c] = memory_write_data[WIDTH-1:0];
                end else begin
                    read_data_d = read_data_d | 4'(mask_q[c]);
                    read_hit_d  = 1'b1;
                end
            end
            irq_req_d[c] = |(factor_q[c] & mask_q[c]);
        end
        // A set arriving with a clear wins so no event is lost.
        factor_d  = (factor_q & ~clr_flags) | set_flags;
        irq_any_d = |irq_req_d;
    end

    // State registers; src_q tracks source during reset to suppress false edges.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q       <= source;
            factor_q    <= '0;
            mask_q      <= '0;
            read_data_q <= 4'h0;
            read_hit_q  <= 1'b0;
            irq_req_q   <= '0;
            irq_any_q   <= 1'b0;
        end else begin
            src_q       <= source;
            factor_q    <= factor_d;
            mask_q      <= mask_d;
            read_data_q <= read_data_d;
            read_hit_q  <= read_hit_d;
            irq_req_q   <= irq_req_d;
            irq_any_q   <= irq_any_d;
        end
    end

    assign read_data = read_data_q;
    assign read_hit  = read_hit_q;
    assign irq_req   = irq_req_q;
    assign irq_any   = irq_any_q;

endmodule

// File: tb/tb_irq_factor_bank.sv
// Testbench for irq_factor_bank: two instances (WIDTH=4 edge mode, WIDTH=2
// level mode) share the CPU bus; a register-level reference model predicts
// every output after every clock edge.
module tb_irq_factor_bank;

    localparam int unsigned CH = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [11:0]       addr;
    logic              we;
    logic [3:0]        wdata;
    logic [CH*4-1:0]   src0;
    logic [CH*2-1:0]   src1;
    logic [3:0]        rd0, rd1;
    logic              hit0, hit1;
    logic [CH-1:0]     irq0, irq1;
    logic              any0, any1;

    irq_factor_bank #(
        .CHANNELS(CH), .WIDTH(4), .FACTOR_BASE(8'h00), .MASK_BASE(8'h10), .EDGE_MODE(1'b1)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .memory_addr(addr), .memory_write_en(we),
        .memory_write_data(wdata), .source(src0), .read_data(rd0), .read_hit(hit0),
        .irq_req(irq0), .irq_any(any0)
    );

    irq_factor_bank #(
        .CHANNELS(CH), .WIDTH(2), .FACTOR_BASE(8'h00), .MASK_BASE(8'h10), .EDGE_MODE(1'b0)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .memory_addr(addr), .memory_write_en(we),
        .memory_write_data(wdata), .source(src1), .read_data(rd1), .read_hit(hit1),
        .irq_req(irq1), .irq_any(any1)
    );

    // Reference model state, one row per instance.
    int width_m[2] = '{4, 2};
    int edge_m[2]  = '{1, 0};
    int fac[2][CH];
    int msk[2][CH];
    int prv[2];
    int e_rd[2], e_hit[2], e_irq[2], e_any[2];

    int tests = 0;
    int fails = 0;

    function automatic int src_of(input int k);
        return (k == 0) ? int'(src0) : int'(src1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict register contents after the coming edge from current inputs.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int s;
            int page;
            int off;
            int w;
            int irqv;
            int nfac[CH];
            s    = src_of(k);
            page = int'(addr) >> 8;
            off  = int'(addr) & 255;
            w    = width_m[k];
            if (!reset_n) begin
                for (int c = 0; c < CH; c++) begin
                    fac[k][c] = 0;
                    msk[k][c] = 0;
                end
                e_rd[k] = 0; e_hit[k] = 0; e_irq[k] = 0; e_any[k] = 0;
                prv[k]  = s;
            end else begin
                irqv = 0;
                for (int c = 0; c < CH; c++) begin
                    if ((fac[k][c] & msk[k][c]) != 0) irqv = irqv | (1 << c);
                    nfac[c] = fac[k][c];
                end
                e_irq[k] = irqv;
                e_any[k] = (irqv != 0) ? 1 : 0;
                e_rd[k]  = 0;
                e_hit[k] = 0;
                if (page == 15 && off < CH && !we) begin
                    e_rd[k]   = fac[k][off];
                    e_hit[k]  = 1;
                    nfac[off] = 0;
                end
                if (page == 15 && off >= 16 && off < 16 + CH) begin
                    if (we) begin
                        msk[k][off-16] = int'(wdata) & ((1 << w) - 1);
                    end else begin
                        e_rd[k]  = msk[k][off-16];
                        e_hit[k] = 1;
                    end
                end
                for (int c = 0; c < CH; c++) begin
                    for (int i = 0; i < w; i++) begin
                        int idx;
                        int cur;
                        int old;
                        idx = c * w + i;
                        cur = (s >> idx) & 1;
                        old = (prv[k] >> idx) & 1;
                        if ((edge_m[k] == 1) ? (cur == 1 && old == 0) : (cur == 1))
                            nfac[c] = nfac[c] | (1 << i);
                    end
                end
                for (int c = 0; c < CH; c++) fac[k][c] = nfac[c];
                prv[k] = s;
            end
        end
    endtask

    // One clock: predict, clock, then compare all outputs of both instances.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("rd0",  32'(rd0),  32'(e_rd[0]));
        check("hit0", 32'(hit0), 32'(e_hit[0]));
        check("irq0", 32'(irq0), 32'(e_irq[0]));
        check("any0", 32'(any0), 32'(e_any[0]));
        check("rd1",  32'(rd1),  32'(e_rd[1]));
        check("hit1", 32'(hit1), 32'(e_hit[1]));
        check("irq1", 32'(irq1), 32'(e_irq[1]));
        check("any1", 32'(any1), 32'(e_any[1]));
    endtask

    task automatic bus(input logic [11:0] a, input logic w, input logic [3:0] d);
        addr = a; we = w; wdata = d;
    endtask

    initial begin
        reset_n = 1'b0;
        bus(12'hE00, 1'b0, 4'h0);
        src0 = '1;
        src1 = '1;

        // Reset with sources high; no edge must be seen after release.
        step();
        step();
        check("reset_rd0", 32'(rd0), 32'h0);
        check("reset_irq0", 32'(irq0), 32'h0);
        reset_n = 1'b1;
        step();
        step();
        bus(12'hF00, 1'b0, 4'h0);
        step();
        check("held_high_rd0", 32'(rd0), 32'h0);
        check("held_high_hit0", 32'(hit0), 32'h1);
        check("held_high_irq0", 32'(irq0), 32'h0);

        // Mask channel 0 with 0011, pulse flag 1, read and clear.
        src0 = '0; src1 = '0;
        bus(12'hF10, 1'b1, 4'h3);
        step();
        bus(12'hE00, 1'b0, 4'h0);
        step();
        src0[1] = 1'b1;
        step();
        src0 = '0;
        step();
        check("pulse_irq0", 32'(irq0[0]), 32'h1);
        bus(12'hF00, 1'b0, 4'h0);
        step();
        check("pulse_read", 32'(rd0), 32'h2);
        bus(12'hE00, 1'b0, 4'h0);
        step();
        check("clear_irq0", 32'(irq0[0]), 32'h0);
        bus(12'hF00, 1'b0, 4'h0);
        step();
        check("reread", 32'(rd0), 32'h0);

        // Set and clear in the same cycle: the set survives.
        bus(12'hE00, 1'b0, 4'h0);
        src0[2] = 1'b1;
        step();
        src0 = '0;
        step();
        bus(12'hF00, 1'b0, 4'h0);
        src0[0] = 1'b1;
        step();
        check("setclr_read", 32'(rd0), 32'h4);
        step();
        check("setclr_after", 32'(rd0), 32'h1);

        // Channel 3 flag 2 sets while masked out, then mask it in.
        src0 = '0;
        bus(12'hE00, 1'b0, 4'h0);
        src0[14] = 1'b1;
        step();
        src0 = '0;
        step();
        check("masked_out_irq", 32'(irq0[3]), 32'h0);
        bus(12'hF13, 1'b1, 4'h4);
        step();
        bus(12'hE00, 1'b0, 4'h0);
        step();
        check("mask_in_irq", 32'(irq0[3]), 32'h1);
        check("mask_in_any", 32'(any0), 32'h1);
        bus(12'hF03, 1'b0, 4'h0);
        step();
        check("ch3_read", 32'(rd0), 32'h4);

        // Mask width truncation, ignored factor write, unmapped address.
        bus(12'hF11, 1'b1, 4'hF);
        step();
        bus(12'hF11, 1'b0, 4'h0);
        step();
        check("mask_w4", 32'(rd0), 32'hF);
        check("mask_w2", 32'(rd1), 32'h3);
        bus(12'hF01, 1'b1, 4'hF);
        step();
        check("fac_write_hit", 32'(hit0), 32'h0);
        bus(12'hF06, 1'b0, 4'h0);
        step();
        check("unmapped_hit", 32'(hit0), 32'h0);
        check("unmapped_rd", 32'(rd0), 32'h0);

        // Level mode: held source re-sets after every clearing read.
        bus(12'hF10, 1'b1, 4'h1);
        step();
        src1[0] = 1'b1;
        bus(12'hF00, 1'b0, 4'h0);
        step();
        for (int n = 0; n < 4; n++) begin
            step();
            check("level_read", 32'(rd1), 32'h1);
            if (n > 0) check("level_irq", 32'(irq1[0]), 32'h1);
        end

        // Randomized traffic, occasional reset.
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom_range(0, 79) != 0);
            case ($urandom_range(0, 3))
                0: addr = 12'hF00 + 12'($urandom_range(0, 7));
                1: addr = 12'hF10 + 12'($urandom_range(0, 7));
                2: addr = 12'($urandom);
                default: addr = 12'hE00 + 12'($urandom_range(0, 31));
            endcase
            we    = ($urandom_range(0, 3) == 0);
            wdata = 4'($urandom);
            src0  = (CH*4)'($urandom & $urandom);
            src1  = ($urandom_range(0, 1) == 0) ? src1 : (CH*2)'($urandom & $urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
